// File: rtl/ex_mem_stage_if.sv
// Bundle of EX-stage inputs, EX/MEM register outputs and the stall flag.
// master drives the EX side; slave is the ex_mem_stage block itself.
interface ex_mem_stage_if;
    logic [31:0] EX_PC;
    logic [31:0] EX_inst;
    logic [31:0] EX_ExtImm;
    logic [31:0] EX_rdataA;
    logic [31:0] EX_rdataB;
    logic        EX_RegWrite;
    logic [1:0]  EX_DataToReg;
    logic        EX_MemWrite;
    logic        EX_ALUSrcA;
    logic        EX_ALUSrcB;
    logic [3:0]  EX_ALUcontrol;
    logic [1:0]  EX_RegDst;
    logic        ex_stall;
    logic [31:0] MEM_PC;
    logic [31:0] MEM_ALUout;
    logic [31:0] MEM_wdata;
    logic [4:0]  MEM_wreg;
    logic        MEM_RegWrite;
    logic [1:0]  MEM_DataToReg;
    logic        MEM_MemWrite;

    modport master (
        output EX_PC, EX_inst, EX_ExtImm, EX_rdataA, EX_rdataB, EX_RegWrite,
               EX_DataToReg, EX_MemWrite, EX_ALUSrcA, EX_ALUSrcB,
               EX_ALUcontrol, EX_RegDst,
        input  ex_stall, MEM_PC, MEM_ALUout, MEM_wdata, MEM_wreg,
               MEM_RegWrite, MEM_DataToReg, MEM_MemWrite
    );

    modport slave (
        input  EX_PC, EX_inst, EX_ExtImm, EX_rdataA, EX_rdataB, EX_RegWrite,
               EX_DataToReg, EX_MemWrite, EX_ALUSrcA, EX_ALUSrcB,
               EX_ALUcontrol, EX_RegDst,
        output ex_stall, MEM_PC, MEM_ALUout, MEM_wdata, MEM_wreg,
               MEM_RegWrite, MEM_DataToReg, MEM_MemWrite
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage: operand muxes, ALU, destination select and EX/MEM register.
// Define EX_MUL_EN to build the iterative shift-add multiplier (ALU code A).
module ex_mem_stage (
    input logic           clk,
    input logic           rst,
    ex_mem_stage_if.slave bus
);
    localparam int         DATA_W = 32;
    localparam logic [3:0] OP_MUL = 4'hA;

    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic        [DATA_W-1:0] mul_res;
    logic        [DATA_W-1:0] alu_res;
    logic        [4:0]        wreg;
    logic                     stall;
    logic                     unused_inst_bits;

    logic [DATA_W-1:0] mem_pc_q;
    logic [DATA_W-1:0] mem_aluout_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [4:0]        mem_wreg_q;
    logic              mem_regwrite_q;
    logic [1:0]        mem_datatoreg_q;
    logic              mem_memwrite_q;

    function automatic logic [DATA_W-1:0] alu_f(
        input logic [3:0]               code,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic [DATA_W-1:0]        prod
    );
        logic [DATA_W-1:0] r;
        case (code)
            4'h0:    r = a & b;
            4'h1:    r = a | b;
            4'h2:    r = a + b;
            4'h3:    r = a ^ b;
            4'h4:    r = ~(a | b);
            4'h5:    r = b >> a[4:0];
            4'h6:    r = a - b;
            4'h7:    r = (a < b) ? 32'd1 : 32'd0;
            4'h8:    r = b << a[4:0];
            4'h9:    r = b >>> a[4:0];
            4'hA:    r = prod;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] dest_f(input logic [1:0] sel, input logic [31:0] inst);
        logic [4:0] d;
        case (sel)
            2'd0:    d = inst[20:16];
            2'd1:    d = inst[15:11];
            2'd2:    d = 5'd31;
            default: d = 5'd0;
        endcase
        return d;
    endfunction

    assign op_a    = bus.EX_ALUSrcA ? {27'b0, bus.EX_inst[10:6]} : bus.EX_rdataA;
    assign op_b    = bus.EX_ALUSrcB ? bus.EX_ExtImm : bus.EX_rdataB;
    assign alu_res = alu_f(bus.EX_ALUcontrol, op_a, op_b, mul_res);
    assign wreg    = dest_f(bus.EX_RegDst, bus.EX_inst);

    assign unused_inst_bits = ^{bus.EX_inst[31:21], bus.EX_inst[5:0]};

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q;
    logic [4:0]        count_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic              is_mul;

    assign is_mul = (bus.EX_ALUcontrol == OP_MUL);
    // One partial product per cycle: add the shifted multiplicand when the current multiplier LSB is set.
    assign acc_d  = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mul) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 5'd1;
                    if (count_q == 5'd31) state_q <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mul_res = acc_q;
    assign stall   = ((state_q == IDLE) && is_mul) || (state_q == BUSY);
`else
    assign mul_res = '0;
    assign stall   = 1'b0;
`endif

    // EX/MEM boundary: a stalled cycle inserts an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            mem_pc_q        <= '0;
            mem_aluout_q    <= '0;
            mem_wdata_q     <= '0;
            mem_wreg_q      <= '0;
            mem_regwrite_q  <= 1'b0;
            mem_datatoreg_q <= '0;
            mem_memwrite_q  <= 1'b0;
        end else begin
            mem_pc_q        <= bus.EX_PC;
            mem_aluout_q    <= alu_res;
            mem_wdata_q     <= bus.EX_rdataB;
            mem_wreg_q      <= wreg;
            mem_regwrite_q  <= bus.EX_RegWrite;
            mem_datatoreg_q <= bus.EX_DataToReg;
            mem_memwrite_q  <= bus.EX_MemWrite;
        end
    end

    assign bus.ex_stall      = stall;
    assign bus.MEM_PC        = mem_pc_q;
    assign bus.MEM_ALUout    = mem_aluout_q;
    assign bus.MEM_wdata     = mem_wdata_q;
    assign bus.MEM_wreg      = mem_wreg_q;
    assign bus.MEM_RegWrite  = mem_regwrite_q;
    assign bus.MEM_DataToReg = mem_datatoreg_q;
    assign bus.MEM_MemWrite  = mem_memwrite_q;
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-002 Ports, listed as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  sync reset, active-high
- EX_PC  in  32  PC of the instruction in EX
- EX_inst  in  32  instruction word in EX
- EX_ExtImm  in  32  extended immediate
- EX_rdataA  in  32  register operand A
- EX_rdataB  in  32  register operand B
- EX_RegWrite  in  1  register write enable
- EX_DataToReg  in  2  writeback select
- EX_MemWrite  in  1  memory write enable
- EX_ALUSrcA  in  1  1 selects shamt
- EX_ALUSrcB  in  1  1 selects ExtImm
- EX_ALUcontrol  in  4  operation code
- EX_RegDst  in  2  destination select
- ex_stall  out  1  holds the ID/EX and upstream registers
- MEM_PC  out  32  registered EX_PC
- MEM_ALUout  out  32  registered result
- MEM_wdata  out  32  registered EX_rdataB (store data)
- MEM_wreg  out  5  registered destination register
- MEM_RegWrite  out  1  registered write enable
- MEM_DataToReg  out  2  registered writeback select
- MEM_MemWrite  out  1  registered memory write enable

Function
REQ-003 Operand A SHALL be {27'b0, EX_inst[10:6]} when EX_ALUSrcA=1, else EX_rdataA.
REQ-004 Operand B SHALL be EX_ExtImm when EX_ALUSrcB=1, else EX_rdataB.
REQ-005 ALU ops (one cycle, combinational), codes in hex:
- 0 AND
- 1 OR
- 2 ADD, wraps mod 2^32
- 3 XOR
- 4 NOR
- 5 SRL B by A[4:0]
- 6 SUB, wraps
- 7 SLT signed, result 1/0
- 8 SLL B by A[4:0]
- 9 SRA B by A[4:0]
- A MUL
- B..F result 0
REQ-006 Destination SHALL be: RegDst 0 -> inst[20:16]; 1 -> inst[15:11]; 2 -> 5'd31; 3 -> 5'd0.
REQ-007 MUL SHALL be an iterative radix-2 shift-add multiplier returning the low 32 bits of A*B (identical for signed and unsigned).
REQ-008 FSM states SHALL be IDLE, BUSY and DONE.
- IDLE with code A: latch A and B, clear the accumulator, count=0, go to BUSY.
- BUSY: one partial-product step per cycle, count+1; at count=31, go to DONE.
- DONE: go to IDLE unconditionally.
REQ-009 ex_stall SHALL be combinational: 1 when (IDLE and code A) or BUSY; otherwise 0.
REQ-010 A MUL seen in IDLE at cycle 0 SHALL hold ex_stall=1 for cycles 0..32 and drop it to 0 in cycle 33 (DONE).
REQ-011 In the DONE cycle, the EX/MEM register SHALL capture the product.
REQ-012 EX/MEM register, each posedge:
- ex_stall=1: capture a bubble (MEM_RegWrite=0, MEM_MemWrite=0, other fields don't-care but deterministic).
- ex_stall=0: capture all fields from the current EX inputs and result.
REQ-013 The operand latch SHALL ignore input changes during BUSY.
REQ-014 Back-to-back MULs: the second MUL SHALL start in the IDLE cycle after DONE, with no lost or duplicated instruction.
REQ-015 Non-MUL instructions SHALL have 1-cycle latency and never assert ex_stall.

Reset
REQ-016 rst SHALL force on the next posedge:
- FSM to IDLE, count 0, accumulator 0
- all MEM_* outputs to 0
REQ-017 rst asserted mid-BUSY SHALL abort the multiply; no result is written.
REQ-018 ex_stall SHALL read 0 the cycle after reset, unless a MUL is presented.

Configuration
REQ-019 Macro EX_MUL_EN.
- Defined: multiplier, FSM and stall logic SHALL be present.
- Undefined: code A SHALL produce result 0 with 1-cycle latency, ex_stall SHALL be tied to 0, and no FSM SHALL be built.

Verification
REQ-020 ADD: A=32'h7FFFFFFF, B=1 -> MEM_ALUout=32'h80000000 next cycle, ex_stall never 1.
REQ-021 SLT: A=-1, B=1 -> 1; SRA with shamt=4, B=32'hF0000000 -> 32'hFF000000.
REQ-022 MUL: A=32'h00012345, B=32'h00000100 -> stall high exactly 33 cycles, then MEM_ALUout=32'h01234500 and MEM_RegWrite=1 exactly once.
REQ-023 MUL: A=32'hFFFFFFFF, B=32'hFFFFFFFF -> MEM_ALUout=32'h00000001; MEM_RegWrite=0 during every stall cycle.
REQ-024 rst pulsed at BUSY count 10 -> next cycle IDLE, all MEM_*=0, ex_stall=0; a re-issued MUL gives the correct product.
REQ-025 Two consecutive MULs (3*5, 7*9) -> results 15 then 63, 33 stall cycles each, 1 non-stall cycle between them.
